// File: rtl/text_terminal_ctrl.sv
// Terminal byte-stream sequencer: owns the character buffer write port, the cursor,
// the ring-buffer scroll origin (first_char) and the cursor blink phase.
module text_terminal_ctrl #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 25,
  parameter int          BLINK_HALF = 12000000,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        cursor_blink_on,
  output logic [10:0] first_char,
  output logic        busy
);

  localparam logic [11:0] BUF_N      = 12'(COLS*ROWS);
  localparam logic [10:0] BUF_LAST   = 11'(COLS*ROWS);
  localparam logic [10:0] ROW_STEP   = 11'(COLS);
  localparam logic [6:0]  LAST_X     = 7'(COLS-1);
  localparam logic [4:0]  LAST_Y     = 5'(ROWS-1);
  localparam int          BW         = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF-1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PUT, S_SCROLL} state_t;

  // Ring-buffer address arithmetic; operands are always below the buffer size.
  function automatic logic [10:0] add_wrap(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= BUF_N) s = s - BUF_N;
    return s[10:0];
  endfunction

  function automatic logic [10:0] sub_wrap(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + BUF_N - {1'b0, b};
    return s[10:0];
  endfunction

  state_t        state_q;
  logic [10:0]   cnt_q;
  logic [10:0]   cell_q;
  logic [10:0]   first_q;
  logic [6:0]    x_q;
  logic [4:0]    y_q;
  logic          wr_en_q, ready_q, busy_q, blink_q;
  logic [10:0]   wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [BW-1:0] blink_cnt_q;
  logic          accept;

  assign accept = char_valid & ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      cnt_q     <= '0;
      cell_q    <= '0;
      first_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= BLANK_CHAR;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (cnt_q == BUF_LAST) begin
            wr_en_q <= 1'b0;
            first_q <= '0;
            cell_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q;
            wr_data_q <= BLANK_CHAR;
            cnt_q     <= cnt_q + 11'd1;
          end
        end
        S_IDLE: begin
          wr_en_q <= 1'b0;
          if (accept) begin
            if (char_in >= 8'h20) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cell_q;
              wr_data_q <= char_in;
              ready_q   <= 1'b0;
              state_q   <= S_PUT;
            end else begin
              case (char_in)
                8'h0D: begin
                  x_q    <= '0;
                  cell_q <= sub_wrap(cell_q, {4'd0, x_q});
                end
                8'h0A: begin
                  if (y_q != LAST_Y) begin
                    y_q    <= y_q + 5'd1;
                    cell_q <= add_wrap(cell_q, ROW_STEP);
                  end else begin
                    // Old top row becomes the new bottom row; blank it after moving the origin.
                    first_q   <= add_wrap(first_q, ROW_STEP);
                    cell_q    <= first_q;
                    x_q       <= '0;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= first_q;
                    wr_data_q <= BLANK_CHAR;
                    cnt_q     <= 11'd1;
                    busy_q    <= 1'b1;
                    ready_q   <= 1'b0;
                    state_q   <= S_SCROLL;
                  end
                end
                8'h08: begin
                  if (x_q != 7'd0) begin
                    x_q    <= x_q - 7'd1;
                    cell_q <= sub_wrap(cell_q, 11'd1);
                  end
                end
                8'h0C: begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  state_q <= S_CLEAR;
                end
                default: ;
              endcase
            end
          end
        end
        S_PUT: begin
          wr_en_q <= 1'b0;
          if (x_q != LAST_X) begin
            x_q     <= x_q + 7'd1;
            cell_q  <= add_wrap(cell_q, 11'd1);
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (y_q != LAST_Y) begin
            // Last column: the next cell in the ring is the start of the next row.
            x_q     <= '0;
            y_q     <= y_q + 5'd1;
            cell_q  <= add_wrap(cell_q, 11'd1);
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            first_q   <= add_wrap(first_q, ROW_STEP);
            cell_q    <= first_q;
            x_q       <= '0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= first_q;
            wr_data_q <= BLANK_CHAR;
            cnt_q     <= 11'd1;
            busy_q    <= 1'b1;
            state_q   <= S_SCROLL;
          end
        end
        S_SCROLL: begin
          if (cnt_q == ROW_STEP) begin
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= add_wrap(cell_q, cnt_q);
            wr_data_q <= BLANK_CHAR;
            cnt_q     <= cnt_q + 11'd1;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else if (accept) begin
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_q     <= ~blink_q;
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign char_ready      = ready_q;
  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;
  assign wr_en           = wr_en_q;
  assign cursor_x        = x_q;
  assign cursor_y        = y_q;
  assign cursor_blink_on = blink_q;
  assign first_char      = first_q;
  assign busy            = busy_q;

endmodule
